// File: rtl/rob_result_buffer.sv
// Slot-indexed result store for a 2-wide ROB: writeback fill, operand read by slot, registered RF commit.
// Optional same-cycle fill-to-read bypass is enabled by defining RESULT_BUF_BYPASS_EN.
module rob_result_buffer #(
   parameter int DATA_W = 32,
   parameter int SLOT_W = 5,
   parameter int SLOTS  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_val_1,
   input  logic [SLOT_W-1:0] alloc_slot_1,
   input  logic              alloc_val_2,
   input  logic [SLOT_W-1:0] alloc_slot_2,
   input  logic              fill_val_1,
   input  logic [SLOT_W-1:0] fill_slot_1,
   input  logic [DATA_W-1:0] fill_data_1,
   input  logic              fill_val_2,
   input  logic [SLOT_W-1:0] fill_slot_2,
   input  logic [DATA_W-1:0] fill_data_2,
   input  logic [SLOT_W-1:0] src00_slot,
   input  logic [SLOT_W-1:0] src01_slot,
   input  logic [SLOT_W-1:0] src10_slot,
   input  logic [SLOT_W-1:0] src11_slot,
   output logic [DATA_W-1:0] src00_data,
   output logic [DATA_W-1:0] src01_data,
   output logic [DATA_W-1:0] src10_data,
   output logic [DATA_W-1:0] src11_data,
   output logic              src00_ready,
   output logic              src01_ready,
   output logic              src10_ready,
   output logic              src11_ready,
   input  logic              commit_val_1,
   input  logic [SLOT_W-1:0] commit_slot_1,
   input  logic              commit_wen_1,
   input  logic [4:0]        commit_waddr_1,
   input  logic              commit_val_2,
   input  logic [SLOT_W-1:0] commit_slot_2,
   input  logic              commit_wen_2,
   input  logic [4:0]        commit_waddr_2,
   output logic              rf_wen_1,
   output logic [4:0]        rf_waddr_1,
   output logic [DATA_W-1:0] rf_wdata_1,
   output logic              rf_wen_2,
   output logic [4:0]        rf_waddr_2,
   output logic [DATA_W-1:0] rf_wdata_2,
   output logic [SLOT_W:0]   pending_cnt,
   output logic              commit_err
);

   logic [DATA_W-1:0] data_r [SLOTS];
   logic [SLOTS-1:0]  ready_r;

   // Read ports 0..3 are the operand sources, 4..5 the two commit lookups.
   logic [SLOT_W-1:0] rd_slot_s  [6];
   logic [DATA_W-1:0] rd_data_s  [6];
   logic              rd_ready_s [6];

   logic              fill_new_1_s;
   logic              fill_new_2_s;
   logic [SLOT_W:0]   pending_nxt_s;

   assign rd_slot_s[0] = src00_slot;
   assign rd_slot_s[1] = src01_slot;
   assign rd_slot_s[2] = src10_slot;
   assign rd_slot_s[3] = src11_slot;
   assign rd_slot_s[4] = commit_slot_1;
   assign rd_slot_s[5] = commit_slot_2;

   assign src00_data  = rd_data_s[0];
   assign src01_data  = rd_data_s[1];
   assign src10_data  = rd_data_s[2];
   assign src11_data  = rd_data_s[3];
   assign src00_ready = rd_ready_s[0];
   assign src01_ready = rd_ready_s[1];
   assign src10_ready = rd_ready_s[2];
   assign src11_ready = rd_ready_s[3];

   // Array lookup for every read port, with fill port 2 overriding port 1 when bypassing.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         rd_data_s[i]  = data_r[rd_slot_s[i]];
         rd_ready_s[i] = ready_r[rd_slot_s[i]];
`ifdef RESULT_BUF_BYPASS_EN
         if (fill_val_2 && (fill_slot_2 == rd_slot_s[i])) begin
            rd_data_s[i]  = fill_data_2;
            rd_ready_s[i] = 1'b1;
         end else if (fill_val_1 && (fill_slot_1 == rd_slot_s[i])) begin
            rd_data_s[i]  = fill_data_1;
            rd_ready_s[i] = 1'b1;
         end else begin
            rd_ready_s[i] = ready_r[rd_slot_s[i]];
         end
`endif
      end
   end

   // A fill only retires a pending entry if the slot was unready and not re-allocated on the same edge.
   always_comb begin
      fill_new_1_s = fill_val_1 && !ready_r[fill_slot_1]
                     && !(alloc_val_1 && (alloc_slot_1 == fill_slot_1))
                     && !(alloc_val_2 && (alloc_slot_2 == fill_slot_1))
                     && !(fill_val_2 && (fill_slot_2 == fill_slot_1));
      fill_new_2_s = fill_val_2 && !ready_r[fill_slot_2]
                     && !(alloc_val_1 && (alloc_slot_1 == fill_slot_2))
                     && !(alloc_val_2 && (alloc_slot_2 == fill_slot_2));
      pending_nxt_s = pending_cnt
                      + (SLOT_W+1)'(alloc_val_1) + (SLOT_W+1)'(alloc_val_2)
                      - (SLOT_W+1)'(fill_new_1_s) - (SLOT_W+1)'(fill_new_2_s);
   end

   // Result data array; deliberately not reset, writes suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_val_1) data_r[fill_slot_1] <= fill_data_1;
         if (fill_val_2) data_r[fill_slot_2] <= fill_data_2;
      end
   end

   // Ready bits: allocation clears after fills so alloc wins a same-slot conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_r     <= '0;
         pending_cnt <= '0;
      end else begin
         if (fill_val_1)  ready_r[fill_slot_1]  <= 1'b1;
         if (fill_val_2)  ready_r[fill_slot_2]  <= 1'b1;
         if (alloc_val_1) ready_r[alloc_slot_1] <= 1'b0;
         if (alloc_val_2) ready_r[alloc_slot_2] <= 1'b0;
         pending_cnt <= pending_nxt_s;
      end
   end

   // Commit stage: registered RF write ports; address and data hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_wen_1   <= 1'b0;
         rf_waddr_1 <= 5'd0;
         rf_wdata_1 <= '0;
         rf_wen_2   <= 1'b0;
         rf_waddr_2 <= 5'd0;
         rf_wdata_2 <= '0;
         commit_err <= 1'b0;
      end else begin
         if (commit_val_1 && commit_wen_1) begin
            rf_wen_1   <= 1'b1;
            rf_waddr_1 <= commit_waddr_1;
            rf_wdata_1 <= rd_data_s[4];
         end else begin
            rf_wen_1   <= 1'b0;
         end
         if (commit_val_2 && commit_wen_2) begin
            rf_wen_2   <= 1'b1;
            rf_waddr_2 <= commit_waddr_2;
            rf_wdata_2 <= rd_data_s[5];
         end else begin
            rf_wen_2   <= 1'b0;
         end
         if ((commit_val_1 && !rd_ready_s[4]) || (commit_val_2 && !rd_ready_s[5])) begin
            commit_err <= 1'b1;
         end
      end
   end

endmodule
